// File: rtl/aes_128_input_framer.sv
// Packs four 32-bit words into a 128-bit block and launches it with a 2-cycle in_en strobe to the AES core.
// Launch 2 cycles after the 4th word when the core is idle; s_ready drops while a full block waits in staging.
module aes_128_input_framer (
    input  logic         clk,
    input  logic         kill,
    input  logic         flush,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         busy,
    output logic [127:0] block_out,
    output logic         in_en,
    output logic [15:0]  launch_cnt,
    output logic         ack_timeout_err
);

    typedef enum logic [2:0] {FILL, READY, L1, L2, ACK} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_stage;
    logic [127:0]   r_block;
    logic [1:0]     r_wd_cnt;
    logic           r_stage_full;
    logic [15:0]    r_launch_cnt;
    logic           r_err;
    logic [2:0]     r_ack_cnt;
    logic           w_xfer;
    logic           w_launch;
    logic           w_timeout;

    assign s_ready         = !r_stage_full && !kill && !flush;
    assign w_xfer          = s_valid && s_ready;
    assign in_en           = ((r_state == L1) || (r_state == L2)) && !kill;
    assign block_out       = r_block;
    assign launch_cnt      = r_launch_cnt;
    assign ack_timeout_err = r_err;

    always_ff @(posedge clk or posedge kill) begin
        if (kill) r_state <= FILL;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            FILL:  if (r_stage_full) w_next = READY;
            READY: if (!busy) begin
                       w_next   = L1;
                       w_launch = 1'b1;
                   end
            L1:    w_next = L2;
            L2:    w_next = ACK;
            ACK:   if (busy) begin
                       w_next = FILL;
                   end else if (r_ack_cnt == 3'd7) begin
                       w_next    = FILL;
                       w_timeout = 1'b1;
                   end
            default: w_next = FILL;
        endcase
        // An in-flight strobe must complete so the core never sees a truncated launch.
        if (flush && (r_state != L1) && (r_state != L2)) begin
            w_next    = FILL;
            w_launch  = 1'b0;
            w_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            r_stage      <= '0;
            r_block      <= '0;
            r_wd_cnt     <= '0;
            r_stage_full <= 1'b0;
            r_launch_cnt <= '0;
            r_err        <= 1'b0;
            r_ack_cnt    <= '0;
        end else begin
            if (flush) begin
                r_wd_cnt     <= '0;
                r_stage_full <= 1'b0;
            end else if (w_launch) begin
                r_stage_full <= 1'b0;
            end else if (w_xfer) begin
                case (r_wd_cnt)
                    2'd0:    r_stage[127:96] <= s_data;
                    2'd1:    r_stage[95:64]  <= s_data;
                    2'd2:    r_stage[63:32]  <= s_data;
                    default: r_stage[31:0]   <= s_data;
                endcase
                r_wd_cnt <= r_wd_cnt + 2'd1;
                if (r_wd_cnt == 2'd3) r_stage_full <= 1'b1;
            end

            if (w_launch) begin
                r_block      <= r_stage;
                r_launch_cnt <= r_launch_cnt + 16'd1;
            end

            if (flush)          r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;

            // Counts idle-core cycles spent waiting in ACK; restarts on every entry.
            if ((r_state == ACK) && (w_next == ACK)) r_ack_cnt <= r_ack_cnt + 3'd1;
            else                                     r_ack_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_aes_128_input_framer.sv
// Scoreboard bench for aes_128_input_framer: accepted words are grouped into expected blocks,
// a monitor pops one expected block per launch strobe and checks data, count and strobe shape.
module tb_aes_128_input_framer;

    logic         clk = 1'b0;
    logic         kill;
    logic         flush;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         busy;
    logic [127:0] block_out;
    logic         in_en;
    logic [15:0]  launch_cnt;
    logic         ack_timeout_err;

    int           checks = 0;
    int           failures = 0;
    logic [127:0] pending[$];
    logic [31:0]  partial[$];
    logic [15:0]  exp_cnt = 16'd0;
    logic         hold_busy = 1'b0;
    logic         core_busy = 1'b0;
    int           core_mode = 0;

    assign busy = hold_busy | core_busy;

    always #5 clk = ~clk;

    aes_128_input_framer dut (
        .clk             (clk),
        .kill            (kill),
        .flush           (flush),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .busy            (busy),
        .block_out       (block_out),
        .in_en           (in_en),
        .launch_cnt      (launch_cnt),
        .ack_timeout_err (ack_timeout_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: every four accepted words, first word most significant, make one block.
    task automatic model_word(input logic [31:0] w);
        partial.push_back(w);
        if (partial.size() == 4) begin
            pending.push_back({partial[0], partial[1], partial[2], partial[3]});
            partial.delete();
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        int  t;
        bit  done;
        t = 0;
        done = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                model_word(w);
                done = 1;
            end else begin
                t++;
                if (t > 300) begin
                    chk("send_word_timeout", 1, 0);
                    done = 1;
                end
            end
        end
        sync();
        s_valid = 1'b0;
    endtask

    task automatic do_flush(input bit with_word);
        flush   = 1'b1;
        s_valid = with_word;
        s_data  = $urandom;
        @(negedge clk);
        #2;
        chk("s_ready_low_during_flush", s_ready, 0);
        partial.delete();
        pending.delete();
        sync();
        flush   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (pending.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", pending.size(), 0);
        repeat (20) @(negedge clk);
        sync();
    endtask

    task automatic wait_in_en(input logic lvl, input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (in_en !== lvl && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (in_en !== lvl) chk(name, in_en, lvl);
    endtask

    // Monitor: one expected block per in_en rising edge; strobe must last exactly 2 cycles.
    initial begin : monitor
        int           run;
        logic         prev_en;
        logic [127:0] prev_blk;
        logic [127:0] exp_blk;
        run = 0;
        prev_en = 1'b0;
        prev_blk = '0;
        forever begin
            @(negedge clk);
            if (kill) begin
                run = 0;
                prev_en = 1'b0;
                prev_blk = '0;
            end else begin
                if (in_en) begin
                    chk("busy_low_during_in_en", busy, 0);
                    if (!prev_en) begin
                        chk("launch_expected", pending.size() > 0, 1);
                        if (pending.size() > 0) begin
                            exp_blk = pending.pop_front();
                            exp_cnt = exp_cnt + 16'd1;
                            chk("block_out", block_out, exp_blk);
                            chk("launch_cnt", launch_cnt, exp_cnt);
                        end
                        run = 1;
                    end else begin
                        run++;
                    end
                end else if (prev_en) begin
                    chk("in_en_width", run, 2);
                end
                if (!(in_en && !prev_en)) chk("block_out_stable", block_out, prev_blk);
                prev_en = in_en;
                prev_blk = block_out;
            end
        end
    end

    // Core model: after each launch strobe, raises busy briefly (mode 0) or never answers (mode 1).
    initial begin : core_model
        logic prev;
        int   d;
        int   len;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (prev && !in_en && core_mode == 0) begin
                d   = $urandom_range(0, 3);
                len = $urandom_range(1, 6);
                repeat (d) @(posedge clk);
                #1 core_busy = 1'b1;
                repeat (len) @(posedge clk);
                #1 core_busy = 1'b0;
                prev = 1'b0;
            end else begin
                prev = in_en;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  r;
        bit  saw_en;
        bit  bp_done;
        int  t;
        kill = 1'b1;
        flush = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_in_en", in_en, 0);
        chk("rst_block_out", block_out, 0);
        chk("rst_launch_cnt", launch_cnt, 0);
        chk("rst_ack_err", ack_timeout_err, 0);
        sync();
        kill = 1'b0;
        @(negedge clk);
        chk("s_ready_after_release", s_ready, 1);
        sync();

        // Basic block
        send_word(32'h00112233);
        send_word(32'h44556677);
        send_word(32'h8899AABB);
        send_word(32'hCCDDEEFF);
        wait_drain();
        chk("basic_block", block_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("basic_cnt", launch_cnt, 1);

        // Partial fill discarded by flush; a word offered during flush is dropped
        send_word(32'hDEAD0001);
        send_word(32'hDEAD0002);
        do_flush(1);
        send_word(32'hA0A0A0A0);
        send_word(32'hB1B1B1B1);
        send_word(32'hC2C2C2C2);
        send_word(32'hD3D3D3D3);
        wait_drain();
        chk("flush_block", block_out, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);

        // Back-pressure: core busy while two blocks are offered
        hold_busy = 1'b1;
        bp_done = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_word(32'h5000_0000 + i);
                bp_done = 1;
            end
        join_none
        saw_en = 0;
        repeat (30) begin
            @(negedge clk);
            saw_en |= in_en;
        end
        chk("bp_no_launch_while_busy", saw_en, 0);
        chk("bp_s_ready_low", s_ready, 0);
        sync();
        hold_busy = 1'b0;
        t = 0;
        while (!bp_done && t < 500) begin
            sync();
            t++;
        end
        chk("bp_all_words_sent", bp_done, 1);
        wait_drain();

        // Ack timeout: core never raises busy
        core_mode = 1;
        for (int i = 0; i < 4; i++) send_word($urandom);
        wait_in_en(1'b1, "timeout_launch_seen");
        wait_in_en(1'b0, "timeout_strobe_end");
        repeat (7) @(negedge clk);
        chk("ack_err_before_8", ack_timeout_err, 0);
        @(negedge clk);
        chk("ack_err_at_8", ack_timeout_err, 1);
        sync();
        do_flush(0);
        @(negedge clk);
        chk("ack_err_cleared_by_flush", ack_timeout_err, 0);
        sync();
        core_mode = 0;

        // Randomized traffic with occasional flushes
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0)     do_flush($urandom_range(0, 1) == 1);
            else if (r < 4) sync();
            else            send_word($urandom);
        end
        partial.delete();
        do_flush(0);
        wait_drain();

        // Counter wrap
        force dut.r_launch_cnt = 16'hFFFF;
        #1;
        release dut.r_launch_cnt;
        exp_cnt = 16'hFFFF;
        sync();
        for (int i = 0; i < 4; i++) send_word($urandom);
        wait_drain();
        chk("wrap_cnt", launch_cnt, 0);

        // Kill during L1
        for (int i = 0; i < 4; i++) send_word($urandom);
        wait_in_en(1'b1, "kill_launch_seen");
        #1 kill = 1'b1;
        #1;
        chk("kill_in_en", in_en, 0);
        chk("kill_cnt", launch_cnt, 0);
        chk("kill_block", block_out, 0);
        chk("kill_s_ready", s_ready, 0);
        partial.delete();
        pending.delete();
        exp_cnt = 16'd0;
        sync();
        sync();
        kill = 1'b0;
        @(negedge clk);
        chk("kill_release_s_ready", s_ready, 1);
        sync();
        for (int i = 0; i < 4; i++) send_word($urandom);
        wait_drain();
        chk("kill_resume_cnt", launch_cnt, 1);

        chk("scoreboard_empty", pending.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
